// File: rtl/seq_divider_pkg.sv
// Shared constants and FSM state type for the iterative signed divider.
package seq_divider_pkg;
  localparam int DEF_WIDTH = 24;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module seq_divider_div_step #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH:0] rem_i,
  input  logic           bit_i,
  input  logic [WIDTH:0] dvs_i,
  output logic [WIDTH:0] rem_o,
  output logic           q_o
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // The partial remainder stays below the divisor, so bit WIDTH+1 of diff is a true sign.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, dvs_i};
  assign q_o     = ~diff[WIDTH+1];
  assign rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];
endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider: one restoring step per clock, result held until consumed.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic [1:0]       dbg_state_o
);
  localparam int CW = $clog2(WIDTH);

  // Handshake: operands transfer on an edge with in_valid & in_ready, results on an
  // edge with out_valid & out_ready; valid never waits on ready and both are registered.
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] num_q;
  logic [WIDTH:0]   dvs_q;
  logic [WIDTH:0]   rem_q;
  logic             sgn_q_q, sgn_r_q, ovf_pend_q;
  logic             in_ready_q, out_valid_q, dz_q, ovf_q;
  logic [WIDTH-1:0] quo_q, rmd_q;

  logic [WIDTH:0]   rem_d;
  logic             qbit_d;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dvs_mag;
  logic             rem_nz;
  logic             ovf_in;

  assign dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = divisor[WIDTH-1] ? ({1'b0, ~divisor} + 1'b1) : {1'b0, divisor};
  assign rem_nz  = |rem_q;
  assign ovf_in  = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (num_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .q_o   (qbit_d)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      sgn_q_q     <= 1'b0;
      sgn_r_q     <= 1'b0;
      ovf_pend_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      quo_q       <= '0;
      rmd_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            sgn_q_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sgn_r_q    <= dividend[WIDTH-1];
            ovf_pend_q <= ovf_in;
            if (divisor == '0) begin
              // Result is known at acceptance; out_valid follows one cycle later in DONE.
              quo_q   <= '1;
              rmd_q   <= dividend;
              dz_q    <= 1'b1;
              ovf_q   <= 1'b0;
              state_q <= DONE;
            end else begin
              num_q   <= dvd_mag;
              dvs_q   <= dvs_mag;
              rem_q   <= '0;
              cnt_q   <= CW'(WIDTH - 1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          num_q <= {num_q[WIDTH-2:0], qbit_d};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= SIGN;
        end
        SIGN: begin
          quo_q       <= sgn_q_q ? (~num_q + 1'b1) : num_q;
          rmd_q       <= (sgn_r_q && rem_nz) ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
          dz_q        <= 1'b0;
          ovf_q       <= ovf_pend_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dz_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed vectors, monitor pops expected results.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int W  = 24;
  localparam int EW = 2 * W + 2;

  logic         clk = 1'b0;
  logic         arst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend, divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero, overflow;
  logic [1:0]   dbg_state;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .arst        (arst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            acc_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // monitor
  logic prev_v = 1'b0;
  logic popped = 1'b0;
  always @(negedge clk) begin
    if (arst) begin
      prev_v = 1'b0;
      popped = 1'b0;
    end else begin
      if (popped) check("valid_drop", EW'(out_valid), EW'(0));
      popped = 1'b0;
      if (out_valid && !prev_v && exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got %h with no pending operation",
                 {quotient, remainder, div_by_zero, overflow});
      end else if (out_valid && exp_q.size() != 0) begin
        if (!prev_v) begin
          check("result", {quotient, remainder, div_by_zero, overflow}, exp_q[0]);
          check("latency", EW'(cyc - acc_q[0]), EW'(lat_q[0]));
        end else begin
          check("hold_stable", {quotient, remainder, div_by_zero, overflow}, exp_q[0]);
        end
        check("in_ready_low", EW'(in_ready), EW'(0));
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          void'(acc_q.pop_front());
          popped = 1'b1;
        end
      end
      prev_v = out_valid;
    end
  end

  // driver
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic dz, input logic ov, input int lat,
                       input bit track, output int acc);
    int t = 0;
    acc = -1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, t);
      return;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    if (track) begin
      exp_q.push_back({eq, er, dz, ov});
      lat_q.push_back(lat);
      acc_q.push_back(cyc);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
    end
  endtask

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dz, ov;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int a1, a2, t;
    vecs[0]  = '{24'd100,    24'd7,      24'd14,     24'd2,      1'b0, 1'b0, 25};
    vecs[1]  = '{24'hFFFF9C, 24'd7,      24'hFFFFF2, 24'hFFFFFE, 1'b0, 1'b0, 25};
    vecs[2]  = '{24'd100,    24'hFFFFF9, 24'hFFFFF2, 24'd2,      1'b0, 1'b0, 25};
    vecs[3]  = '{24'hFFFF9C, 24'hFFFFF9, 24'd14,     24'hFFFFFE, 1'b0, 1'b0, 25};
    vecs[4]  = '{24'd7,      24'd0,      24'hFFFFFF, 24'd7,      1'b1, 1'b0, 1};
    vecs[5]  = '{24'h800000, 24'hFFFFFF, 24'h800000, 24'd0,      1'b0, 1'b1, 25};
    vecs[6]  = '{24'h7FFFFF, 24'd1,      24'h7FFFFF, 24'd0,      1'b0, 1'b0, 25};
    vecs[7]  = '{24'hFFFFFB, 24'd0,      24'hFFFFFF, 24'hFFFFFB, 1'b1, 1'b0, 1};
    vecs[8]  = '{24'd3,      24'd5,      24'd0,      24'd3,      1'b0, 1'b0, 25};
    vecs[9]  = '{24'hFFFFFD, 24'd5,      24'd0,      24'hFFFFFD, 1'b0, 1'b0, 25};
    vecs[10] = '{24'h800000, 24'd2,      24'hC00000, 24'd0,      1'b0, 1'b0, 25};
    vecs[11] = '{24'h7FFFFF, 24'h800000, 24'd0,      24'h7FFFFF, 1'b0, 1'b0, 25};

    // reset block
    arst      = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  EW'(in_ready),    EW'(1));
    check("rst_out_valid", EW'(out_valid),   EW'(0));
    check("rst_quotient",  EW'(quotient),    EW'(0));
    check("rst_remainder", EW'(remainder),   EW'(0));
    check("rst_dz",        EW'(div_by_zero), EW'(0));
    check("rst_ovf",       EW'(overflow),    EW'(0));
    check("rst_state",     EW'(dbg_state),   EW'(IDLE));
    @(negedge clk);
    arst = 1'b0;

    // directed vectors, out_ready held high
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov,
            vecs[i].lat, 1'b1, a1);
      drain();
    end

    // back-to-back throughput
    do_op(24'd100, 24'd7, 24'd14, 24'd2, 1'b0, 1'b0, 25, 1'b1, a1);
    do_op(24'd1000, 24'd10, 24'd100, 24'd0, 1'b0, 1'b0, 25, 1'b1, a2);
    check("throughput", EW'(a2 - a1), EW'(W + 3));
    drain();

    // backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    do_op(24'd100, 24'd7, 24'd14, 24'd2, 1'b0, 1'b0, 25, 1'b1, a1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      n_checks++;
      $display("FAIL out_valid_timeout: out_valid=%0b after %0d cycles, want 1", out_valid, t);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dividend = 24'd5;
      divisor  = 24'd1;
      in_valid = (i % 2 == 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_handoff", EW'(in_ready), EW'(1));
    do_op(24'h7FFFFF, 24'd1, 24'h7FFFFF, 24'd0, 1'b0, 1'b0, 25, 1'b1, a1);
    drain();

    // reset in the middle of CALC
    do_op(24'd100, 24'd7, 24'd0, 24'd0, 1'b0, 1'b0, 25, 1'b0, a1);
    repeat (10) @(posedge clk);
    #2;
    arst = 1'b1;
    #1;
    check("mid_rst_in_ready",  EW'(in_ready),  EW'(1));
    check("mid_rst_out_valid", EW'(out_valid), EW'(0));
    check("mid_rst_quotient",  EW'(quotient),  EW'(0));
    check("mid_rst_remainder", EW'(remainder), EW'(0));
    check("mid_rst_state",     EW'(dbg_state), EW'(IDLE));
    #3;
    arst = 1'b0;
    do_op(24'd100, 24'd7, 24'd14, 24'd2, 1'b0, 1'b0, 25, 1'b1, a1);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
